// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU execute stage.
//   - datapath / register-address widths
//   - ALU operation codes, forwarding selects, branch funct3 codes,
//     writeback (ResultSrc) encodings
//   - EX/MEM pipeline register layout
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int REGW  = 3;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Forwarding selects from the hazard unit (2'b11 falls back to the register value)
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Branch condition codes (funct3)
  localparam logic [2:0] BR_EQ = 3'b000;
  localparam logic [2:0] BR_NE = 3'b001;
  localparam logic [2:0] BR_LT = 3'b100;
  localparam logic [2:0] BR_GE = 3'b101;

  // Writeback select encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic             regwrite;
    logic             memwrite;
    logic [1:0]       result_src;
    logic [REGW-1:0]  rd;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] pc_plus4;
  } exmem_t;

endpackage

// File: rtl/execute_cycle_if.sv
// Execute-stage bus bundle.
//   master : decode / hazard / writeback side; drives ID/EX controls and
//            operands, forwarding selects and ResultW; receives the redirect
//            and the EX/MEM register outputs.
//   slave  : the execute stage itself.
interface execute_cycle_if;
  import cpu_pkg::*;

  // ID/EX inputs
  logic             RegwriteE;
  logic             MemwriteE;
  logic             JumpE;
  logic             branchE;
  logic             ALUSrcE;
  logic [1:0]       ResultSrcE;
  logic [3:0]       ALUControlE;
  logic [2:0]       funct3E;
  logic [WIDTH-1:0] RD1E;
  logic [WIDTH-1:0] RD2E;
  logic [WIDTH-1:0] immExtE;
  logic [WIDTH-1:0] PCE;
  logic [WIDTH-1:0] pc_plus4E;
  logic [REGW-1:0]  RdE;

  // Hazard unit / writeback
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [WIDTH-1:0] ResultW;

  // Redirect to fetch (combinational)
  logic             PCSrcE;
  logic [WIDTH-1:0] PCTargetE;

  // EX/MEM register outputs
  logic             RegwriteM;
  logic             MemwriteM;
  logic [1:0]       ResultSrcM;
  logic [REGW-1:0]  RdM;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] WriteDataM;
  logic [WIDTH-1:0] pc_plus4M;

  modport master (
    output RegwriteE, MemwriteE, JumpE, branchE, ALUSrcE, ResultSrcE,
           ALUControlE, funct3E, RD1E, RD2E, immExtE, PCE, pc_plus4E, RdE,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegwriteM, MemwriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, pc_plus4M
  );

  modport slave (
    input  RegwriteE, MemwriteE, JumpE, branchE, ALUSrcE, ResultSrcE,
           ALUControlE, funct3E, RD1E, RD2E, immExtE, PCE, pc_plus4E, RdE,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegwriteM, MemwriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, pc_plus4M
  );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit ALU.
//   a, b : operands
//   ctrl : operation code (see cpu_pkg ALU_*)
//   y    : result; undefined codes give zero
module alu
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] y
);

  logic [3:0] shamt;
  assign shamt = b[3:0];

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 16-bit pipelined CPU.
//   clk, rst : clock and synchronous active-high reset
//   ex       : slave side of execute_cycle_if carrying the ID/EX inputs,
//              forwarding selects, ResultW, the combinational redirect
//              (PCSrcE/PCTargetE) and the EX/MEM register outputs.
// Resolves operand forwarding, runs the ALU, resolves branches/jumps and
// registers the result into EX/MEM every clock (no stall, no enable).
module execute_cycle
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  execute_cycle_if.slave ex
);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_y;
  logic             br_cond;
  exmem_t           exmem_d;
  exmem_t           exmem_q;

  // Operand forwarding; select 2'b11 deliberately falls back to the register value
  always_comb begin
    src_a = ex.RD1E;
    case (ex.ForwardAE)
      FWD_WB:  src_a = ex.ResultW;
      FWD_MEM: src_a = ex.ALUResultM;
      default: src_a = ex.RD1E;
    endcase
  end

  always_comb begin
    fwd_b = ex.RD2E;
    case (ex.ForwardBE)
      FWD_WB:  fwd_b = ex.ResultW;
      FWD_MEM: fwd_b = ex.ALUResultM;
      default: fwd_b = ex.RD2E;
    endcase
  end

  // The immediate only feeds the ALU; store data and branch compare use fwd_b
  assign src_b = ex.ALUSrcE ? ex.immExtE : fwd_b;

  alu u_alu (
    .a    (src_a),
    .b    (src_b),
    .ctrl (ex.ALUControlE),
    .y    (alu_y)
  );

  always_comb begin
    br_cond = 1'b0;
    case (ex.funct3E)
      BR_EQ:   br_cond = (src_a == fwd_b);
      BR_NE:   br_cond = (src_a != fwd_b);
      BR_LT:   br_cond = ($signed(src_a) <  $signed(fwd_b));
      BR_GE:   br_cond = ($signed(src_a) >= $signed(fwd_b));
      default: br_cond = 1'b0;
    endcase
  end

  // Redirect is forced quiet while reset is held so fetch never jumps during reset
  assign ex.PCSrcE    = ~rst & (ex.JumpE | (ex.branchE & br_cond));
  assign ex.PCTargetE = rst ? '0 : (ex.PCE + ex.immExtE);

  always_comb begin
    exmem_d            = '0;
    exmem_d.regwrite   = ex.RegwriteE;
    exmem_d.memwrite   = ex.MemwriteE;
    exmem_d.result_src = ex.ResultSrcE;
    exmem_d.rd         = ex.RdE;
    exmem_d.alu_result = alu_y;
    exmem_d.write_data = fwd_b;
    exmem_d.pc_plus4   = ex.pc_plus4E;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign ex.RegwriteM  = exmem_q.regwrite;
  assign ex.MemwriteM  = exmem_q.memwrite;
  assign ex.ResultSrcM = exmem_q.result_src;
  assign ex.RdM        = exmem_q.rd;
  assign ex.ALUResultM = exmem_q.alu_result;
  assign ex.WriteDataM = exmem_q.write_data;
  assign ex.pc_plus4M  = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases followed by random
// transactions compared against an arithmetic reference model.
module tb_execute_cycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_cycle_if ex_if ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  typedef struct packed {
    logic        r;
    logic        regw;
    logic        memw;
    logic        jump;
    logic        br;
    logic        alusrc;
    logic [1:0]  rsrc;
    logic [3:0]  aluc;
    logic [2:0]  f3;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] pc4;
    logic [2:0]  rd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] resw;
  } txn_t;

  int total = 0;
  int bad   = 0;
  int txn_no = 0;

  // Bench-side view of what ALUResultM should currently hold
  logic [15:0] m_alu;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sval(input logic [15:0] v);
    int u;
    u = int'({16'b0, v});
    return (u >= 32768) ? (u - 65536) : u;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sh, sa;
    ua = int'({16'b0, a});
    ub = int'({16'b0, b});
    sh = ub % 16;
    sa = sval(a);
    case (op)
      4'd0:    return 16'(ua + ub);
      4'd1:    return 16'(ua - ub);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return 16'(ua * (1 << sh));
      4'd6:    return 16'(ua / (1 << sh));
      4'd7:    return 16'(sa >>> sh);
      4'd8:    return (sval(a) < sval(b)) ? 16'd1 : 16'd0;
      4'd9:    return (ua < ub) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [15:0] a, input logic [15:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sval(a) <  sval(b);
      3'd5:    return sval(a) >= sval(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] reg_v,
                                       input logic [15:0] wb_v, input logic [15:0] mem_v);
    if (sel == 2'd1) return wb_v;
    if (sel == 2'd2) return mem_v;
    return reg_v;
  endfunction

  // Called at posedge+1: drive, check redirect, then check EX/MEM one clock later
  task automatic run_txn(input txn_t t);
    logic [15:0] a, fb, b, exp_alu, exp_tgt;
    logic        exp_pcsrc;
    rst               = t.r;
    ex_if.RegwriteE   = t.regw;
    ex_if.MemwriteE   = t.memw;
    ex_if.JumpE       = t.jump;
    ex_if.branchE     = t.br;
    ex_if.ALUSrcE     = t.alusrc;
    ex_if.ResultSrcE  = t.rsrc;
    ex_if.ALUControlE = t.aluc;
    ex_if.funct3E     = t.f3;
    ex_if.RD1E        = t.rd1;
    ex_if.RD2E        = t.rd2;
    ex_if.immExtE     = t.imm;
    ex_if.PCE         = t.pc;
    ex_if.pc_plus4E   = t.pc4;
    ex_if.RdE         = t.rd;
    ex_if.ForwardAE   = t.fa;
    ex_if.ForwardBE   = t.fb;
    ex_if.ResultW     = t.resw;

    a  = pick(t.fa, t.rd1, t.resw, m_alu);
    fb = pick(t.fb, t.rd2, t.resw, m_alu);
    b  = t.alusrc ? t.imm : fb;
    exp_alu   = ref_alu(t.aluc, a, b);
    exp_pcsrc = t.r ? 1'b0 : (t.jump || (t.br && ref_taken(t.f3, a, fb)));
    exp_tgt   = t.r ? 16'h0000 : 16'(int'({16'b0, t.pc}) + int'({16'b0, t.imm}));

    #1;
    check("pcsrc", {15'b0, ex_if.PCSrcE}, {15'b0, exp_pcsrc});
    check("pctarget", ex_if.PCTargetE, exp_tgt);

    @(posedge clk);
    #1;
    if (t.r) begin
      exp_alu = 16'h0000;
      fb      = 16'h0000;
    end
    check("regwrite_m",  {15'b0, ex_if.RegwriteM}, t.r ? 16'h0 : {15'b0, t.regw});
    check("memwrite_m",  {15'b0, ex_if.MemwriteM}, t.r ? 16'h0 : {15'b0, t.memw});
    check("resultsrc_m", {14'b0, ex_if.ResultSrcM}, t.r ? 16'h0 : {14'b0, t.rsrc});
    check("rd_m",        {13'b0, ex_if.RdM}, t.r ? 16'h0 : {13'b0, t.rd});
    check("aluresult_m", ex_if.ALUResultM, exp_alu);
    check("writedata_m", ex_if.WriteDataM, fb);
    check("pc_plus4_m",  ex_if.pc_plus4M, t.r ? 16'h0 : t.pc4);
    m_alu = exp_alu;
    $display("txn %0d rst=%0d op=%h f3=%0d a=%h b=%h alu=%h pcsrc=%0d tgt=%h",
             txn_no, t.r, t.aluc, t.f3, a, b, exp_alu, exp_pcsrc, exp_tgt);
    txn_no++;
  endtask

  txn_t t;

  initial begin
    t = '0;
    m_alu = 16'h0000;
    // Reset state: hold reset with write enables asserted
    t.r = 1'b1; t.regw = 1'b1; t.memw = 1'b1;
    @(posedge clk); #1;
    run_txn(t);

    // Seed ALUResultM = 5
    t = '0; t.aluc = 4'b0000; t.rd1 = 16'h0005; t.rd2 = 16'h0000; t.regw = 1'b1; t.rd = 3'd1;
    run_txn(t);
    // ADD forwarded from M -> 8
    t = '0; t.aluc = 4'b0000; t.fa = 2'b10; t.rd1 = 16'h1234; t.rd2 = 16'h0003; t.regw = 1'b1; t.rd = 3'd2;
    run_txn(t);
    // SUB forwarded from W with wrap -> FFFF
    t = '0; t.aluc = 4'b0001; t.fa = 2'b01; t.resw = 16'h0000; t.rd1 = 16'h7777; t.rd2 = 16'h0001; t.regw = 1'b1; t.rd = 3'd3;
    run_txn(t);
    // Immediate store
    t = '0; t.aluc = 4'b0000; t.alusrc = 1'b1; t.imm = 16'hFFFE; t.rd1 = 16'h0010; t.rd2 = 16'hABCD; t.memw = 1'b1;
    run_txn(t);
    // BLT taken, target 001C
    t = '0; t.br = 1'b1; t.f3 = 3'b100; t.pc = 16'h0020; t.imm = 16'hFFFC; t.rd1 = 16'h8000; t.rd2 = 16'h0001; t.aluc = 4'b0001;
    run_txn(t);
    // BGE with the same operands: not taken
    t.f3 = 3'b101;
    run_txn(t);
    // Branch compare ignores immediate even with ALUSrcE set
    t = '0; t.br = 1'b1; t.f3 = 3'b000; t.alusrc = 1'b1; t.imm = 16'h0004; t.rd1 = 16'h0009; t.rd2 = 16'h0009; t.pc = 16'h0100;
    run_txn(t);
    // Jump
    t = '0; t.jump = 1'b1; t.pc4 = 16'h0024; t.rsrc = 2'b10; t.pc = 16'h0020; t.imm = 16'h0040; t.regw = 1'b1; t.rd = 3'd7;
    run_txn(t);
    // Reset mid-operation with enables high and a jump pending
    t.r = 1'b1; t.memw = 1'b1;
    run_txn(t);
    // After reset drops, next instruction propagates normally
    t = '0; t.aluc = 4'b0011; t.rd1 = 16'h00F0; t.rd2 = 16'h0F00; t.regw = 1'b1; t.rd = 3'd5; t.pc4 = 16'h0044;
    run_txn(t);

    // Random transactions
    for (int i = 0; i < 300; i++) begin
      t.r      = ($urandom_range(0, 15) == 0);
      t.regw   = 1'($urandom);
      t.memw   = 1'($urandom);
      t.jump   = ($urandom_range(0, 7) == 0);
      t.br     = 1'($urandom);
      t.alusrc = 1'($urandom);
      t.rsrc   = 2'($urandom);
      t.aluc   = 4'($urandom_range(0, 11));
      t.f3     = 3'($urandom);
      t.rd1    = 16'($urandom);
      t.rd2    = ($urandom_range(0, 3) == 0) ? t.rd1 : 16'($urandom);
      t.imm    = 16'($urandom);
      t.pc     = 16'($urandom);
      t.pc4    = 16'($urandom);
      t.rd     = 3'($urandom);
      t.fa     = 2'($urandom);
      t.fb     = 2'($urandom);
      t.resw   = 16'($urandom);
      run_txn(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
